instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: 16-bit PC, one outstanding instruction-memory read,
// 2-entry {instr, pc} queue toward decode, redirect handling with drop of in-flight data.
//   state | meaning
//   IDLE  | one cycle after reset release, no request
//   FETCH | request at pc outstanding, push on ack
//   FULL  | queue holds two entries, no request
//   DROP  | stale request after redirect, discard its ack
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          PC_STEP  = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic [15:0] instr_pc
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL, S_DROP} state_t;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_pc, w_pc_nxt;
   logic [15:0] r_drop_addr, w_drop_addr_nxt;
   logic [15:0] r_instr [2];
   logic [15:0] r_ipc   [2];
   logic        r_rd_ptr, r_wr_ptr;
   logic [1:0]  r_cnt;
   logic        w_push, w_pop;
   logic [1:0]  w_cnt_after;

   assign instr_valid = (r_cnt != 2'd0);
   assign w_pop       = instr_valid & ~stall & ~redirect;
   assign w_push      = (r_state == S_FETCH) & imem_ack & ~redirect;
   assign w_cnt_after = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

   assign instr    = instr_valid ? r_instr[r_rd_ptr] : 16'h0000;
   assign instr_pc = instr_valid ? r_ipc[r_rd_ptr]   : 16'h0000;
   assign opcode   = instr[15:12];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_drop_addr <= RESET_PC;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_drop_addr <= w_drop_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_drop_addr_nxt = r_drop_addr;
      imem_req        = 1'b0;
      imem_addr       = r_pc;
      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_FETCH;
            if (redirect) w_pc_nxt = redirect_pc;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (redirect) begin
               w_pc_nxt = redirect_pc;
               if (!imem_ack) begin
                  w_state_nxt     = S_DROP;
                  w_drop_addr_nxt = r_pc;
               end
            end else if (imem_ack) begin
               w_pc_nxt = r_pc + 16'(PC_STEP);
               if (w_cnt_after == 2'd2) w_state_nxt = S_FULL;
            end
         end
         S_FULL: begin
            if (redirect) begin
               w_pc_nxt    = redirect_pc;
               w_state_nxt = S_FETCH;
            end else if (w_pop) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_DROP: begin
            // the memory still sees the pre-redirect address until it answers
            imem_req  = 1'b1;
            imem_addr = r_drop_addr;
            if (redirect) w_pc_nxt = redirect_pc;
            if (imem_ack) w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= 2'd0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_instr[0] <= 16'h0000;
         r_instr[1] <= 16'h0000;
         r_ipc[0]   <= 16'h0000;
         r_ipc[1]   <= 16'h0000;
      end else if (redirect) begin
         r_cnt    <= 2'd0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
      end else begin
         if (w_push) begin
            r_instr[r_wr_ptr] <= imem_data;
            r_ipc[r_wr_ptr]   <= r_pc;
            r_wr_ptr          <= ~r_wr_ptr;
         end
         if (w_pop) r_rd_ptr <= ~r_rd_ptr;
         r_cnt <= w_cnt_after;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected {instr, pc} pairs are queued when an ack
// is offered and compared when decode pops the head.
module tb_instr_fetch;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_data = 16'h0000;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        instr_valid;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [15:0] instr_pc;

   entry_t q[$];
   entry_t exp_item;
   logic   exp_push  = 1'b0;
   logic   exp_flush = 1'b0;
   int     n_chk  = 0;
   int     n_pass = 0;

   instr_fetch #(.RESET_PC(16'h0000), .PC_STEP(2)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One clock: check/pop the head, take the edge, then update the model.
   task automatic tick();
      entry_t e;
      chk("valid", {15'd0, instr_valid}, {15'd0, q.size() != 0});
      if (instr_valid && !stall && !redirect && q.size() > 0) begin
         e = q.pop_front();
         chk("pop_instr", instr, e.instr);
         chk("pop_pc", instr_pc, e.pc);
         chk("pop_opcode", {12'd0, opcode}, {12'd0, e.instr[15:12]});
      end else if (!instr_valid) begin
         chk("empty_instr", instr, 16'h0000);
      end
      @(posedge clk);
      #1;
      if (exp_flush) q.delete();
      else if (exp_push) q.push_back(exp_item);
      exp_flush = 1'b0;
      exp_push  = 1'b0;
      imem_ack  = 1'b0;
      redirect  = 1'b0;
   endtask

   task automatic ack(input logic [15:0] data, input logic [15:0] addr, input logic accept);
      chk("ack_req", {15'd0, imem_req}, 16'd1);
      chk("ack_addr", imem_addr, addr);
      imem_ack  = 1'b1;
      imem_data = data;
      if (accept) begin
         exp_item = '{instr: data, pc: addr};
         exp_push = 1'b1;
      end
   endtask

   task automatic do_reset();
      stall    = 1'b0;
      imem_ack = 1'b0;
      redirect = 1'b0;
      reset    = 1'b0;
      @(posedge clk);
      #1;
      q.delete();
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset values while held
      #1;
      chk("rst_req", {15'd0, imem_req}, 16'd0);
      chk("rst_addr", imem_addr, 16'h0000);
      chk("rst_valid", {15'd0, instr_valid}, 16'd0);

      // basic fetch; an ack during IDLE is ignored
      do_reset();
      chk("idle_req", {15'd0, imem_req}, 16'd0);
      imem_ack = 1'b1; imem_data = 16'h1234;
      tick();
      chk("hold_addr", imem_addr, 16'h0000);
      tick();
      ack(16'hF123, 16'h0000, 1'b1); tick();
      ack(16'h8456, 16'h0002, 1'b1); tick();
      chk("next_addr", imem_addr, 16'h0004);
      tick();
      tick();

      // stall fills the queue, third ack offered while FULL
      do_reset();
      stall = 1'b1;
      tick();
      ack(16'hA001, 16'h0000, 1'b1); tick();
      ack(16'hA002, 16'h0002, 1'b1); tick();
      chk("full_req", {15'd0, imem_req}, 16'd0);
      imem_ack = 1'b1; imem_data = 16'hA003;
      tick();
      chk("full_req2", {15'd0, imem_req}, 16'd0);
      chk("head_stable", instr, 16'hA001);
      tick();
      stall = 1'b0;
      tick();
      chk("resume_req", {15'd0, imem_req}, 16'd1);
      chk("resume_addr", imem_addr, 16'h0004);
      tick();
      tick();

      // redirect with request pending and no ack -> DROP
      do_reset();
      stall = 1'b1;
      tick();
      ack(16'h1111, 16'h0000, 1'b1); tick();
      redirect = 1'b1; redirect_pc = 16'h0040; exp_flush = 1'b1;
      tick();
      chk("drop_req", {15'd0, imem_req}, 16'd1);
      chk("drop_addr", imem_addr, 16'h0002);
      tick();
      chk("drop_addr2", imem_addr, 16'h0002);
      imem_ack = 1'b1; imem_data = 16'h2222;
      tick();
      chk("redir_req", {15'd0, imem_req}, 16'd1);
      chk("redir_addr", imem_addr, 16'h0040);
      tick();
      stall = 1'b0;

      // redirect together with ack and a would-be pop
      do_reset();
      tick();
      ack(16'h3333, 16'h0000, 1'b1); tick();
      ack(16'h4444, 16'h0002, 1'b0);
      redirect = 1'b1; redirect_pc = 16'h0100; exp_flush = 1'b1;
      tick();
      chk("same_addr", imem_addr, 16'h0100);
      chk("same_req", {15'd0, imem_req}, 16'd1);
      tick();

      // PC wrap, entered via redirect in IDLE
      do_reset();
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      tick();
      chk("wrap_start", imem_addr, 16'hFFFE);
      ack(16'h5555, 16'hFFFE, 1'b1); tick();
      chk("wrap_addr", imem_addr, 16'h0000);
      tick();

      // asynchronous reset mid-FETCH
      do_reset();
      stall = 1'b1;
      tick();
      ack(16'h6666, 16'h0000, 1'b1); tick();
      chk("pre_addr", imem_addr, 16'h0002);
      #2;
      reset = 1'b0;
      #1;
      chk("async_req", {15'd0, imem_req}, 16'd0);
      chk("async_addr", imem_addr, 16'h0000);
      chk("async_valid", {15'd0, instr_valid}, 16'd0);
      chk("async_instr", instr, 16'h0000);
      chk("async_opcode", {12'd0, opcode}, 16'h0000);
      chk("async_pc", instr_pc, 16'h0000);
      q.delete();
      stall = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      chk("post_req", {15'd0, imem_req}, 16'd1);
      chk("post_addr", imem_addr, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
